pc_gen: RTL and testbench
=========================

// Module: pc_gen
// PURPOSE
//  Parametrised fetch program-counter generator; successor to the single-cycle PC register.
//  Adds the following over the single-cycle PC register: reset vector, stall, trap redirect,
//  misaligned-target flag, and a return-address stack (RAS) for call/return prediction.
//  Sits at the head of the IF stage and drives instruction-memory address and pc+4 to the pipeline.
// PARAMETERS
//  XLEN       32            PC / data width in bits
//  RESET_VEC  32'h0000_0000 PC value loaded on reset
//  RAS_DEPTH  4             return-address stack entries (power of 2, >=2)
// PORTS
//  clk        in   1     clock, all state updates on rising edge
//  rst        in   1     asynchronous, active-high reset
//  stall      in   1     hold PC; no RAS push/pop
//  br_sel     in   1     resolved branch/jump taken: redirect to alu_data
//  alu_data   in   XLEN  resolved branch/jump target
//  trap_en    in   1     trap/exception: redirect to trap_vec, clear RAS
//  trap_vec   in   XLEN  trap handler address
//  is_call    in   1     pre-decode: instruction at pc is a call (jal/jalr, rd=x1/x5)
//  is_ret     in   1     pre-decode: instruction at pc is a return (jalr x0,0(x1/x5))
//  pc         out  XLEN  current fetch address
//  pc_four    out  XLEN  pc + 4 (combinational)
//  ras_hit    out  1     current cycle's next-PC taken from RAS top (combinational)
//  misalign   out  1     registered: last redirect target had bit 1 set
// BEHAVIOUR
//  Reset (async): pc=RESET_VEC, misalign=0, RAS ptr=0, count=0, entries=0.
//  Next-PC priority, evaluated every cycle:
//   1 trap_en             -> trap_vec & ~2'b11; RAS count:=0; ignores stall
//   2 br_sel              -> {alu_data[XLEN-1:1],1'b0}; ignores stall
//   3 stall               -> pc unchanged
//   4 is_ret & count>0    -> RAS top; ras_hit=1
//   5 otherwise           -> pc_four (includes is_ret with empty RAS)
//  misalign <= bit1 of selected target when rule 1 or 2 fires; else 0.
//   Pipeline raises the exception.
//  Latency: one cycle from any input to pc; pc_four and ras_hit combinational.
//  RAS updates only when rules 4/5 fire (fetch advances, no redirect):
//   - push on is_call: write pc_four at ptr+1, ptr++, count=min(count+1,RAS_DEPTH).
//   - pop on is_ret & count>0: ptr--, count--.
//   - is_call & is_ret together: pop-then-push; top replaced with pc_four, count unchanged.
//   - overflow: ptr wraps mod RAS_DEPTH, oldest entry overwritten, count saturates.
//   - underflow: pop with count==0 is ignored; ptr unchanged.
//  br_sel leaves RAS untouched (mispredicted returns corrected by br_sel, no repair).
//  trap clears count only; entry contents are don't-care.
//  Arithmetic: pc_four wraps modulo 2^XLEN; no overflow flag.
// STRUCTURE
//  Package pc_pkg: typedef logic [XLEN-1:0] addr_t; localparam RESET_VEC default;
//  enum nxt_sel_e {SEL_TRAP,SEL_BR,SEL_HOLD,SEL_RAS,SEL_SEQ}.
//  Sub-module ras_stack (storage, ptr, count, push/pop/replace, clear). pc_gen keeps next-PC mux and pc/misalign regs.
// TESTING
//  1 Assert rst mid-run with pc=0x40 -> pc=RESET_VEC immediately (async); after release pc 0x0,0x4,0x8.
//  2 stall=1 for 3 cycles at pc=0x10 -> pc stays 0x10; br_sel=1, alu_data=0x201 with stall -> pc=0x200, misalign=0.
//  3 alu_data=0x102, br_sel=1 -> pc=0x102, misalign=1 for one cycle.
//  4 call at 0x100 (push 0x104), target 0x300; ret at 0x308 -> ras_hit=1, pc=0x104, count back to 0.
//  5 RAS_DEPTH+1 nested calls then RAS_DEPTH+1 rets -> newest RAS_DEPTH addresses returned LIFO; last ret ras_hit=0, pc=pc+4.
//  6 trap_en with trap_vec=0x80 and br_sel same cycle -> pc=0x80, RAS emptied; next ret gives ras_hit=0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and defaults for the fetch program-counter generator.
package pc_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] addr_t;

    localparam addr_t RESET_VEC = 32'h0000_0000;

    // Source of the next fetch address, listed from highest to lowest priority.
    typedef enum logic [2:0] {
        SEL_TRAP,
        SEL_BR,
        SEL_HOLD,
        SEL_RAS,
        SEL_SEQ
    } nxt_sel_e;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-side bundle between the pipeline control and the PC generator.
interface pc_gen_if #(
    parameter int XLEN = 32
) ();

    logic            stall;
    logic            br_sel;
    logic [XLEN-1:0] alu_data;
    logic            trap_en;
    logic [XLEN-1:0] trap_vec;
    logic            is_call;
    logic            is_ret;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_four;
    logic            ras_hit;
    logic            misalign;

    modport master (
        output stall, br_sel, alu_data, trap_en, trap_vec, is_call, is_ret,
        input  pc, pc_four, ras_hit, misalign
    );

    modport slave (
        input  stall, br_sel, alu_data, trap_en, trap_vec, is_call, is_ret,
        output pc, pc_four, ras_hit, misalign
    );

endinterface

// File: rtl/pc_gen_ras_stack.sv
// Circular return-address stack: ptr addresses the top entry, count tracks
// how many entries are valid (saturating at the depth, oldest overwritten).
module ras_stack #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            valid
);
    import pc_pkg::*;

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] mem_reg [RAS_DEPTH];
    logic [PW-1:0]   ptr_reg, ptr_next, wr_ptr;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            pop_eff;

    // A pop on an empty stack is dropped; pop+push lands on the same slot.
    assign pop_eff = pop && (cnt_reg != '0);
    assign wr_ptr  = pop_eff ? ptr_reg : ptr_reg + PW'(1);
    assign top     = mem_reg[ptr_reg];
    assign valid   = (cnt_reg != '0);

    // Pointer and occupancy update; clear only forgets the contents' validity.
    always_comb begin
        ptr_next = ptr_reg;
        cnt_next = cnt_reg;
        if (push) begin
            ptr_next = wr_ptr;
        end else if (pop_eff) begin
            ptr_next = ptr_reg - PW'(1);
        end
        if (clr) begin
            cnt_next = '0;
        end else if (push && !pop_eff) begin
            cnt_next = (cnt_reg == CW'(RAS_DEPTH)) ? cnt_reg : cnt_reg + CW'(1);
        end else if (pop_eff && !push) begin
            cnt_next = cnt_reg - CW'(1);
        end
    end

    // Pointer/occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= '0;
            cnt_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
            cnt_reg <= cnt_next;
        end
    end

    generate
        for (genvar gi = 0; gi < RAS_DEPTH; gi++) begin : g_entry
            // Each entry captures the return address when it is the write target.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mem_reg[gi] <= '0;
                end else if (push && (wr_ptr == PW'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: prioritised next-PC mux, PC/misalign registers and a
// return-address stack for call/return prediction.
module pc_gen #(
    parameter int              XLEN      = pc_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_VEC = pc_pkg::RESET_VEC,
    parameter int              RAS_DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst,
    pc_gen_if.slave bus
);
    import pc_pkg::*;

    logic [XLEN-1:0] pc_reg, pc_next, pc_four;
    logic [XLEN-1:0] trap_target, br_target, ras_top;
    logic            misalign_reg, misalign_next;
    logic            ras_valid, advance;
    nxt_sel_e        sel;

    assign pc_four     = pc_reg + XLEN'(4);
    assign trap_target = bus.trap_vec & ~XLEN'(3);
    assign br_target   = {bus.alu_data[XLEN-1:1], 1'b0};

    // Pick the next-PC source by priority: trap, branch, stall, RAS, sequential.
    always_comb begin
        sel = SEL_SEQ;
        if (bus.trap_en) begin
            sel = SEL_TRAP;
        end else if (bus.br_sel) begin
            sel = SEL_BR;
        end else if (bus.stall) begin
            sel = SEL_HOLD;
        end else if (bus.is_ret && ras_valid) begin
            sel = SEL_RAS;
        end
    end

    // Next-PC value and misaligned-redirect flag for the selected source.
    always_comb begin
        pc_next       = pc_four;
        misalign_next = 1'b0;
        case (sel)
            SEL_TRAP: begin
                pc_next       = trap_target;
                misalign_next = trap_target[1];
            end
            SEL_BR: begin
                pc_next       = br_target;
                misalign_next = bus.alu_data[1];
            end
            SEL_HOLD: pc_next = pc_reg;
            SEL_RAS:  pc_next = ras_top;
            default:  pc_next = pc_four;
        endcase
    end

    // PC and misalign registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg       <= RESET_VEC;
            misalign_reg <= 1'b0;
        end else begin
            pc_reg       <= pc_next;
            misalign_reg <= misalign_next;
        end
    end

    // The stack only moves when fetch advances without a redirect.
    assign advance = (sel == SEL_RAS) || (sel == SEL_SEQ);

    ras_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .clr       (bus.trap_en),
        .push      (advance && bus.is_call),
        .pop       (advance && bus.is_ret),
        .push_data (pc_four),
        .top       (ras_top),
        .valid     (ras_valid)
    );

    assign bus.pc       = pc_reg;
    assign bus.pc_four  = pc_four;
    assign bus.ras_hit  = (sel == SEL_RAS);
    assign bus.misalign = misalign_reg;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: a behavioural model predicts each cycle's
// next PC/misalign into a scoreboard queue, checked after the clock edge.
module tb_pc_gen;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic        mis;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    logic [31:0] m_pc;
    logic [31:0] ras_q[$];
    exp_t        sb[$];

    pc_gen_if #(.XLEN(32)) bus ();

    pc_gen #(
        .XLEN      (32),
        .RESET_VEC (32'h0),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // One fetch cycle: drive at negedge, check combinational outputs, predict,
    // then compare registered outputs after the rising edge.
    task automatic step(input bit st, input bit br, input logic [31:0] ad,
                        input bit tr, input logic [31:0] tv,
                        input bit call, input bit ret);
        logic [31:0] nxt;
        logic        mis;
        logic        hit;
        exp_t        e;
        bus.stall    = st;
        bus.br_sel   = br;
        bus.alu_data = ad;
        bus.trap_en  = tr;
        bus.trap_vec = tv;
        bus.is_call  = call;
        bus.is_ret   = ret;
        #1;
        hit = !tr && !br && !st && ret && (ras_q.size() > 0);
        check("pc_four", bus.pc_four, m_pc + 32'd4);
        check("ras_hit", {31'd0, bus.ras_hit}, {31'd0, hit});
        mis = 1'b0;
        if (tr) begin
            nxt = {tv[31:2], 2'b00};
            ras_q.delete();
        end else if (br) begin
            nxt = {ad[31:1], 1'b0};
            mis = ad[1];
        end else if (st) begin
            nxt = m_pc;
        end else begin
            nxt = hit ? ras_q[$] : m_pc + 32'd4;
            if (ret && ras_q.size() > 0) void'(ras_q.pop_back());
            if (call) ras_q.push_back(m_pc + 32'd4);
            if (ras_q.size() > DEPTH) void'(ras_q.pop_front());
        end
        e.pc  = nxt;
        e.mis = mis;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("pc", bus.pc, e.pc);
        check("misalign", {31'd0, bus.misalign}, {31'd0, e.mis});
        $display("step pc=%h st=%0d br=%0d tr=%0d call=%0d ret=%0d hit=%0d -> pc=%h mis=%0d",
                 m_pc, st, br, tr, call, ret, hit, bus.pc, bus.misalign);
        m_pc = e.pc;
        @(negedge clk);
    endtask

    task automatic seq(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic jump(input logic [31:0] t);
        step(0, 1, t, 0, 0, 0, 0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.stall = 0; bus.br_sel = 0; bus.alu_data = 0; bus.trap_en = 0;
        bus.trap_vec = 0; bus.is_call = 0; bus.is_ret = 0;
        m_pc = 32'h0;
        @(negedge clk);
        check("reset_pc", bus.pc, 32'h0);
        check("reset_mis", {31'd0, bus.misalign}, 32'd0);
        rst = 1'b0;

        // Async reset mid-run at pc 0x40, then restart from the vector.
        seq(16);
        check("pc_at_40", bus.pc, 32'h40);
        #2 rst = 1'b1;
        #1;
        check("async_rst_pc", bus.pc, 32'h0);
        check("async_rst_mis", {31'd0, bus.misalign}, 32'd0);
        m_pc = 32'h0;
        ras_q.delete();
        @(negedge clk);
        rst = 1'b0;
        check("post_rst_pc", bus.pc, 32'h0);
        seq(2);
        check("post_rst_8", bus.pc, 32'h8);

        // Stall holds; branch overrides stall.
        seq(2);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0);
        check("stall_hold", bus.pc, 32'h10);
        step(1, 1, 32'h201, 0, 0, 0, 0);
        check("br_over_stall", bus.pc, 32'h200);

        // Misaligned branch target flags for one cycle.
        jump(32'h102);
        check("mis_set", {31'd0, bus.misalign}, 32'd1);
        seq(1);
        check("mis_clear", {31'd0, bus.misalign}, 32'd0);

        // Call at 0x100, return from 0x308.
        jump(32'h100);
        step(0, 0, 0, 0, 0, 1, 0);
        jump(32'h300);
        seq(2);
        step(0, 0, 0, 0, 0, 0, 1);
        check("ret_pc", bus.pc, 32'h104);

        // Depth+1 nested calls, then depth+1 returns.
        for (int i = 0; i <= DEPTH; i++) begin
            step(0, 0, 0, 0, 0, 1, 0);
            jump(32'h1000 * (i + 1));
        end
        for (int i = 0; i <= DEPTH; i++) step(0, 0, 0, 0, 0, 0, 1);
        check("underflow_seq", bus.pc, 32'h1004 + 32'h4);

        // Trap with simultaneous branch wins and empties the stack.
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 1, 32'h500, 1, 32'h80, 0, 0);
        check("trap_pc", bus.pc, 32'h80);
        step(0, 0, 0, 0, 0, 0, 1);
        check("trap_ret_pc", bus.pc, 32'h84);

        // Call and return together replace the top entry.
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 1);

        // Mixed random traffic against the model.
        for (int i = 0; i < 80; i++) begin
            step(($urandom % 5) == 0, ($urandom % 6) == 0, $urandom,
                 ($urandom % 15) == 0, $urandom,
                 ($urandom % 3) == 0, ($urandom % 3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
